// File: rtl/stop_conditioner_pkg.sv
// Shared definitions for the stacker stop-button conditioner: channel count,
// debounce default, order-FSM encoding and the FSM register bundle.
package stop_conditioner_pkg;

  localparam int SC_NUM_BUTTONS     = 4;
  localparam int SC_DEBOUNCE_CYCLES = 500000;

  localparam logic [2:0] ST_WAIT3 = 3'd0;
  localparam logic [2:0] ST_WAIT2 = 3'd1;
  localparam logic [2:0] ST_WAIT1 = 3'd2;
  localparam logic [2:0] ST_WAIT0 = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [2:0] state;
    logic [3:0] accept;
    logic [3:0] hold_n;
    logic       order_err;
    logic       done;
  } fsm_out_t;

  localparam fsm_out_t FSM_RESET = '{
    state:     ST_WAIT3,
    accept:    4'b0000,
    hold_n:    4'b1111,
    order_err: 1'b0,
    done:      1'b0
  };

  // One-hot mask of the button the order FSM is waiting for.
  function automatic logic [3:0] expected_mask(input logic [2:0] st);
    logic [3:0] m;
    case (st)
      ST_WAIT3: m = 4'b1000;
      ST_WAIT2: m = 4'b0100;
      ST_WAIT1: m = 4'b0010;
      ST_WAIT0: m = 4'b0001;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] next_state(input logic [2:0] st);
    logic [2:0] n;
    case (st)
      ST_WAIT3: n = ST_WAIT2;
      ST_WAIT2: n = ST_WAIT1;
      ST_WAIT1: n = ST_WAIT0;
      ST_WAIT0: n = ST_DONE;
      ST_DONE:  n = ST_DONE;
      default:  n = ST_WAIT3;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stop_conditioner_if.sv
// Key/rearm inputs and stop/accept outputs of the stop conditioner.
// The game side is the master; the conditioner is the slave.
interface stop_conditioner_if;

  logic [stop_conditioner_pkg::SC_NUM_BUTTONS-1:0] KeyIn;
  logic                                            Rearm;
  logic [stop_conditioner_pkg::SC_NUM_BUTTONS-1:0] StopPulse;
  logic [stop_conditioner_pkg::SC_NUM_BUTTONS-1:0] AcceptPulse;
  logic [stop_conditioner_pkg::SC_NUM_BUTTONS-1:0] StopHoldN;
  logic                                            OrderError;
  logic                                            Done;

  modport master (
    output KeyIn,
    output Rearm,
    input  StopPulse,
    input  AcceptPulse,
    input  StopHoldN,
    input  OrderError,
    input  Done
  );

  modport slave (
    input  KeyIn,
    input  Rearm,
    output StopPulse,
    output AcceptPulse,
    output StopHoldN,
    output OrderError,
    output Done
  );

endinterface

// File: rtl/stop_conditioner_key_debounce.sv
// Single button channel: 2-flop synchroniser, stability counter, debounced
// pressed level and a registered one-cycle press pulse.
module key_debounce
  import stop_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SC_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_n,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             db_r;
  logic             db_d_r;
  logic             pulse_r;
  logic             mismatch_s;

  // The synchroniser carries the active-low key, so a press shows as 0.
  assign mismatch_s  = (~sync2_r) != db_r;
  assign press_pulse = pulse_r;

  // Two-stage synchroniser for the asynchronous key; idles at released.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter: db follows the key only after a full run of mismatches.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_r <= {CNT_W{1'b0}};
      db_r  <= 1'b0;
    end else if (!mismatch_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
      db_r  <= ~db_r;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Rising-edge detector on the debounced level; releases make no pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      db_d_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      db_d_r  <= db_r;
      pulse_r <= db_r & ~db_d_r;
    end
  end

endmodule

// File: rtl/stop_conditioner.sv
// Stacker stop-button conditioner: four debounced channels feeding an order
// FSM that accepts presses 3,2,1,0 and holds sticky active-low stop levels.
module stop_conditioner
  import stop_conditioner_pkg::*;
#(
  parameter int NUM_BUTTONS     = SC_NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES = SC_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input logic               Clock,
  input logic               Reset,
  stop_conditioner_if.slave bus
);

  logic [NUM_BUTTONS-1:0] stop_pulse_s;
  logic [3:0]             expect_s;
  logic [3:0]             hit_s;
  logic [2:0]             adv_state_s;
  fsm_out_t               fsm_r;
  fsm_out_t               fsm_nxt_s;

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_key (
      .Clock       (Clock),
      .Reset       (Reset),
      .key_n       (bus.KeyIn[gi]),
      .press_pulse (stop_pulse_s[gi])
    );
  end

  // Order tracking: accept the expected press, flag presses on channels still pending.
  always_comb begin
    fsm_nxt_s           = fsm_r;
    fsm_nxt_s.accept    = 4'b0000;
    fsm_nxt_s.order_err = 1'b0;
    expect_s            = expected_mask(fsm_r.state);
    hit_s               = stop_pulse_s & expect_s;
    adv_state_s         = next_state(fsm_r.state);
    if (bus.Rearm) begin
      fsm_nxt_s.state  = ST_WAIT3;
      fsm_nxt_s.hold_n = 4'b1111;
      fsm_nxt_s.done   = 1'b0;
    end else if (fsm_r.state == ST_DONE) begin
      fsm_nxt_s.done = 1'b1;
    end else begin
      // hold_n still high marks a channel that is not yet accepted.
      fsm_nxt_s.order_err = |(stop_pulse_s & fsm_r.hold_n & ~expect_s);
      if (|hit_s) begin
        fsm_nxt_s.accept = hit_s;
        fsm_nxt_s.hold_n = fsm_r.hold_n & ~hit_s;
        fsm_nxt_s.state  = adv_state_s;
        fsm_nxt_s.done   = (adv_state_s == ST_DONE);
      end else begin
        fsm_nxt_s.state = fsm_r.state;
      end
    end
  end

  // Order FSM and all of its outputs are registered together.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fsm_r <= FSM_RESET;
    end else begin
      fsm_r <= fsm_nxt_s;
    end
  end

  assign bus.StopPulse   = stop_pulse_s;
  assign bus.AcceptPulse = fsm_r.accept;
  assign bus.StopHoldN   = fsm_r.hold_n;
  assign bus.OrderError  = fsm_r.order_err;
  assign bus.Done        = fsm_r.done;

endmodule

// File: tb/tb_stop_conditioner.sv
// Scoreboard bench for stop_conditioner with a short debounce window: an
// edge-indexed reference model predicts output events, a monitor checks them.
module tb_stop_conditioner;
  import stop_conditioner_pkg::*;

  localparam int DEB  = 4;
  localparam int CW   = 3;
  localparam int MAXE = 4096;

  typedef struct packed {
    int         e;
    logic [3:0] sp;
    logic [3:0] ap;
    logic [3:0] hn;
    logic       oe;
    logic       dn;
  } ev_t;

  logic Clock;
  logic Reset;
  stop_conditioner_if bus ();

  stop_conditioner #(
    .NUM_BUTTONS     (4),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CW)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   edge_no  = 0;
  int   n_acc    = 0;
  int   oe_seen  = 0;
  int   sp3_seen = 0;
  ev_t  exp_q[$];

  logic [3:0] key_at [MAXE];
  bit         rst_at [MAXE];
  logic [3:0] db_at  [MAXE];
  logic [3:0] sp_at  [MAXE];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Synchronised key as seen by the debouncer on edge x: the raw key two edges back,
  // or released if a reset edge sits in between.
  function automatic logic [3:0] key_seen(input int x);
    if (x < 2) return 4'hF;
    if (rst_at[x-1] || rst_at[x-2]) return 4'hF;
    return key_at[x-2];
  endfunction

  // Reference model, evaluated once per rising edge from the driven inputs only.
  initial begin : model
    logic [3:0] seen, sp, ap, hn, p, m_hn;
    logic       oe, dn, tog, m_dn;
    int         e, x, xc;
    ev_t        ev;
    key_at[0] = 4'hF; rst_at[0] = 1'b1; db_at[0] = 4'h0; sp_at[0] = 4'h0;
    m_hn = 4'hF; m_dn = 1'b0;
    forever begin
      @(posedge Clock);
      if (edge_no < MAXE - 1) begin
        edge_no   = edge_no + 1;
        e         = edge_no;
        key_at[e] = bus.KeyIn;
        rst_at[e] = Reset;
        // db flips once the key has disagreed with it on DEB consecutive edges
        // with no reset and no earlier flip inside that run.
        for (int i = 0; i < 4; i++) begin
          tog = 1'b0;
          if (!Reset) begin
            tog = 1'b1;
            for (int k = 0; k < DEB; k++) begin
              x = e - k;
              if (x < 1 || rst_at[x]) begin
                tog = 1'b0;
              end else begin
                seen = key_seen(x);
                if (k > 0 && db_at[x][i] != db_at[x-1][i]) tog = 1'b0;
                if ((~seen[i]) == db_at[x-1][i]) tog = 1'b0;
              end
            end
          end
          db_at[e][i] = Reset ? 1'b0 : (db_at[e-1][i] ^ tog);
        end
        sp = (Reset || e < 2) ? 4'h0 : (db_at[e-1] & ~db_at[e-2]);
        sp_at[e] = sp;
        p  = sp_at[e-1];
        ap = 4'h0;
        oe = 1'b0;
        if (Reset || bus.Rearm) begin
          n_acc = 0;
        end else if (n_acc < 4) begin
          xc = 3 - n_acc;
          for (int j = 0; j < xc; j++) if (p[j]) oe = 1'b1;
          if (p[xc]) begin
            ap[xc] = 1'b1;
            n_acc  = n_acc + 1;
          end
        end
        hn = 4'hF;
        for (int j = 0; j < n_acc; j++) hn[3-j] = 1'b0;
        dn = (n_acc == 4);
        if (sp != 4'h0 || ap != 4'h0 || oe || hn != m_hn || dn != m_dn) begin
          ev = '{e: e, sp: sp, ap: ap, hn: hn, oe: oe, dn: dn};
          exp_q.push_back(ev);
        end
        m_hn = hn;
        m_dn = dn;
      end
    end
  end

  // Monitor: whenever the DUT shows a pulse or a level change, pop and compare.
  initial begin : monitor
    logic [3:0] prev_hn;
    logic       prev_dn;
    ev_t        ev;
    prev_hn = 4'hF;
    prev_dn = 1'b0;
    forever begin
      @(negedge Clock);
      if (edge_no >= 1) begin
        if (bus.OrderError === 1'b1) oe_seen = oe_seen + 1;
        if (bus.StopPulse[3] === 1'b1) sp3_seen = sp3_seen + 1;
        if (bus.StopPulse !== 4'h0 || bus.AcceptPulse !== 4'h0 || bus.OrderError !== 1'b0 ||
            bus.StopHoldN !== prev_hn || bus.Done !== prev_dn) begin
          n_cmp = n_cmp + 1;
          if (exp_q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL unexpected_event edge=%0d got sp=%b ap=%b hn=%b oe=%b dn=%b, none required",
                     edge_no, bus.StopPulse, bus.AcceptPulse, bus.StopHoldN, bus.OrderError, bus.Done);
          end else begin
            ev = exp_q.pop_front();
            if (ev.e != edge_no || ev.sp !== bus.StopPulse || ev.ap !== bus.AcceptPulse ||
                ev.hn !== bus.StopHoldN || ev.oe !== bus.OrderError || ev.dn !== bus.Done) begin
              n_fail = n_fail + 1;
              $display("FAIL event got edge=%0d sp=%b ap=%b hn=%b oe=%b dn=%b required edge=%0d sp=%b ap=%b hn=%b oe=%b dn=%b",
                       edge_no, bus.StopPulse, bus.AcceptPulse, bus.StopHoldN, bus.OrderError, bus.Done,
                       ev.e, ev.sp, ev.ap, ev.hn, ev.oe, ev.dn);
            end
          end
        end
        prev_hn = bus.StopHoldN;
        prev_dn = bus.Done;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic check(input string name, input int got, input int req);
    n_cmp = n_cmp + 1;
    if (got != req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stoppulse"},   int'(bus.StopPulse),   0);
    check({tag, "_acceptpulse"}, int'(bus.AcceptPulse), 0);
    check({tag, "_stopholdn"},   int'(bus.StopHoldN),   15);
    check({tag, "_ordererror"},  int'(bus.OrderError),  0);
    check({tag, "_done"},        int'(bus.Done),        0);
  endtask

  task automatic press(input int ch);
    bus.KeyIn[ch] = 1'b0;
    tick(8);
    bus.KeyIn[ch] = 1'b1;
    tick(8);
  endtask

  task automatic rearm();
    bus.Rearm = 1'b1;
    tick(1);
    bus.Rearm = 1'b0;
    tick(2);
  endtask

  initial begin : driver
    int e0, lat, base, k;
    Reset     = 1'b1;
    bus.KeyIn = 4'hF;
    bus.Rearm = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    Reset = 1'b0;

    // Idle keys: nothing may happen.
    tick(50);

    // Bounces shorter than the debounce window, then a steady press of button 3.
    for (int r = 0; r < 5; r++) begin
      bus.KeyIn[3] = 1'b0;
      tick(3);
      bus.KeyIn[3] = 1'b1;
      tick(3);
    end
    e0 = edge_no;
    bus.KeyIn[3] = 1'b0;
    lat = -1;
    for (int w = 0; w < 20 && lat < 0; w++) begin
      tick(1);
      if (bus.AcceptPulse[3] === 1'b1) lat = edge_no - e0;
    end
    check("press3_latency", lat, 8);
    check("holdn_after_3", int'(bus.StopHoldN), 4'b0111);
    tick(4);
    bus.KeyIn[3] = 1'b1;
    tick(10);

    // Remaining buttons in order.
    base = oe_seen;
    press(2);
    check("holdn_after_2", int'(bus.StopHoldN), 4'b0011);
    press(1);
    check("holdn_after_1", int'(bus.StopHoldN), 4'b0001);
    press(0);
    check("holdn_after_0", int'(bus.StopHoldN), 4'b0000);
    check("done_after_0", int'(bus.Done), 1);
    check("in_order_errors", oe_seen - base, 0);

    // Out-of-order press from WAIT3, then a legal press.
    rearm();
    check("holdn_after_rearm", int'(bus.StopHoldN), 4'b1111);
    base = oe_seen;
    press(1);
    check("out_of_order_errors", oe_seen - base, 1);
    check("holdn_after_bad", int'(bus.StopHoldN), 4'b1111);
    press(3);
    check("holdn_after_late3", int'(bus.StopHoldN), 4'b0111);

    // Rearm on the same edge that sees StopPulse[2]: rearm wins.
    bus.KeyIn[2] = 1'b0;
    tick(7);
    check("sp2_coincident", int'(bus.StopPulse[2]), 1);
    bus.Rearm = 1'b1;
    tick(1);
    bus.Rearm = 1'b0;
    check("rearm_accept", int'(bus.AcceptPulse), 0);
    check("rearm_holdn", int'(bus.StopHoldN), 4'b1111);
    bus.KeyIn[2] = 1'b1;
    tick(10);
    press(3);
    check("holdn_after_rearm3", int'(bus.StopHoldN), 4'b0111);

    // Reset while button 3 is mid-count, held through and after the reset.
    bus.KeyIn[3] = 1'b0;
    tick(4);
    Reset = 1'b1;
    tick(2);
    check_reset_outputs("midcount");
    Reset = 1'b0;
    base = sp3_seen;
    tick(20);
    check("post_reset_sp3", sp3_seen - base, 1);
    check("post_reset_holdn", int'(bus.StopHoldN), 4'b0111);
    bus.KeyIn[3] = 1'b1;
    tick(10);

    // Randomised segments, biased toward the button the order expects next.
    for (int s = 0; s < 250; s++) begin
      k = $urandom_range(0, 15);
      if (k == 0) begin
        bus.Rearm = 1'b1;
        tick(1);
        bus.Rearm = 1'b0;
      end else if (k == 1) begin
        Reset = 1'b1;
        tick($urandom_range(1, 2));
        Reset = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 1 && n_acc < 4) k = 3 - n_acc;
        else k = $urandom_range(0, 3);
        bus.KeyIn[k] = ~bus.KeyIn[k];
        if ($urandom_range(0, 5) == 0) bus.KeyIn = bus.KeyIn ^ 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) bus.Rearm = 1'b1;
        tick(1);
        bus.Rearm = 1'b0;
        tick($urandom_range(0, 10));
      end
    end

    bus.KeyIn = 4'hF;
    bus.Rearm = 1'b0;
    Reset     = 1'b0;
    tick(20);
    while (exp_q.size() > 0) begin
      ev_t ev;
      ev = exp_q.pop_front();
      n_cmp  = n_cmp + 1;
      n_fail = n_fail + 1;
      $display("FAIL missing_event got nothing required edge=%0d sp=%b ap=%b hn=%b oe=%b dn=%b",
               ev.e, ev.sp, ev.ap, ev.hn, ev.oe, ev.dn);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
